// File: rtl/io.sv
// Memory-mapped I/O peripheral: LEDs, push-button, switch bank, scratch and ID registers.
// Define IO_DEBOUNCE_EN to debounce the synchronised button before it reaches BUTTON/BTN_EVT.
module io #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic [15:0] ID_VALUE        = 16'h10A5
) (
   input  logic        clk,
   input  logic        sync_rst,
   input  logic [15:0] addr,
   input  logic [15:0] data,
   input  logic        write,
   output logic [15:0] data_out,
   output logic [7:0]  LED,
   input  logic        button_1,
   input  logic [3:0]  switches
);

   localparam logic [15:0] ADDR_BUTTON   = 16'h0000;
   localparam logic [15:0] ADDR_SWITCHES = 16'h0001;
   localparam logic [15:0] ADDR_LED      = 16'h0002;
   localparam logic [15:0] ADDR_BTN_EVT  = 16'h0003;
   localparam logic [15:0] ADDR_SCRATCH  = 16'h0004;
   localparam logic [15:0] ADDR_ID       = 16'h0005;

   logic       btn_meta_q, btn_sync_q;
   logic [3:0] sw_meta_q,  sw_sync_q;
   logic       btn;
   logic       btn_q;
   logic [7:0] led_q, led_d;
   logic [15:0] scratch_q, scratch_d;
   logic       evt_q, evt_d;
   logic       btn_rise;

   // Two-flop synchronisers for the asynchronous board pins.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         sw_meta_q  <= 4'h0;
         sw_sync_q  <= 4'h0;
      end else begin
         btn_meta_q <= button_1;
         btn_sync_q <= btn_meta_q;
         sw_meta_q  <= switches;
         sw_sync_q  <= sw_meta_q;
      end
   end

`ifdef IO_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deb_q, deb_d;

   // Level only flips after the input has disagreed with it for DEBOUNCE_CYCLES clocks.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (btn_sync_q != deb_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = ~deb_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   assign btn = deb_q;
`else
   assign btn = btn_sync_q;
`endif

   assign btn_rise = btn & ~btn_q;

   // NOTE: each comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      led_d     = led_q;
      scratch_d = scratch_q;
      evt_d     = evt_q;
      if (write && addr == ADDR_LED)     led_d     = data[7:0];
      if (write && addr == ADDR_SCRATCH) scratch_d = data;
      if (write && addr == ADDR_BTN_EVT && data[0]) evt_d = 1'b0;
      // A new edge in the same cycle as a clear must not be lost.
      if (btn_rise) evt_d = 1'b1;
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         btn_q     <= 1'b0;
         led_q     <= 8'h00;
         scratch_q <= 16'h0000;
         evt_q     <= 1'b0;
      end else begin
         btn_q     <= btn;
         led_q     <= led_d;
         scratch_q <= scratch_d;
         evt_q     <= evt_d;
      end
   end

   always_comb begin
      data_out = 16'h0000;
      case (addr)
         ADDR_BUTTON:   data_out = {15'h0000, btn};
         ADDR_SWITCHES: data_out = {12'h000, sw_sync_q};
         ADDR_LED:      data_out = {8'h00, led_q};
         ADDR_BTN_EVT:  data_out = {15'h0000, evt_q};
         ADDR_SCRATCH:  data_out = scratch_q;
         ADDR_ID:       data_out = ID_VALUE;
         default:       data_out = 16'h0000;
      endcase
   end

   assign LED = led_q;

endmodule

// File: tb/tb_io.sv
// Directed self-checking bench for the io peripheral (both plain and IO_DEBOUNCE_EN builds).
module tb_io;

   logic        clk = 1'b0;
   logic        sync_rst;
   logic [15:0] addr;
   logic [15:0] data;
   logic        write;
   logic [15:0] data_out;
   logic [7:0]  LED;
   logic        button_1;
   logic [3:0]  switches;

   int total = 0;
   int bad   = 0;

   io #(.DEBOUNCE_CYCLES(16), .ID_VALUE(16'h10A5)) dut (
      .clk      (clk),
      .sync_rst (sync_rst),
      .addr     (addr),
      .data     (data),
      .write    (write),
      .data_out (data_out),
      .LED      (LED),
      .button_1 (button_1),
      .switches (switches)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%04h expected=%04h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      addr  = a;
      data  = d;
      write = 1'b1;
      tick();
      write = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
      addr = a;
      #1;
      check(tag, data_out, exp);
   endtask

   initial begin
      sync_rst = 1'b1;
      addr     = 16'h0000;
      data     = 16'h0000;
      write    = 1'b0;
      button_1 = 1'b0;
      switches = 4'h0;
      repeat (2) tick();

      check("rst_led", {8'h00, LED}, 16'h0000);
      for (int i = 0; i < 5; i++) rd("rst_rd", 16'(i), 16'h0000);
      rd("id_in_rst", 16'h0005, 16'h10A5);

      // First write after release lands on the first edge.
      sync_rst = 1'b0;
      do_write(16'h0002, 16'h00FF);
      check("post_rst_led", {8'h00, LED}, 16'h00FF);
      do_write(16'h0004, 16'h1234);
      rd("scratch_1234", 16'h0004, 16'h1234);

      // Asynchronous reset mid-cycle.
      @(posedge clk);
      #3;
      sync_rst = 1'b1;
      #1;
      check("async_rst_led", {8'h00, LED}, 16'h0000);
      rd("async_rst_rd_led", 16'h0002, 16'h0000);
      rd("async_rst_rd_scr", 16'h0004, 16'h0000);
      tick();
      sync_rst = 1'b0;

      // LED register and RO write.
      do_write(16'h0002, 16'hABCD);
      check("led_cd", {8'h00, LED}, 16'h00CD);
      rd("rd_led_cd", 16'h0002, 16'h00CD);
      do_write(16'h0000, 16'hFFFF);
      check("led_after_ro_wr", {8'h00, LED}, 16'h00CD);
      rd("button_ro", 16'h0000, 16'h0000);
      do_write(16'h0102, 16'h0077);
      check("led_no_alias", {8'h00, LED}, 16'h00CD);

      // Held write strobe.
      addr  = 16'h0002;
      data  = 16'h0055;
      write = 1'b1;
      repeat (4) tick();
      write = 1'b0;
      check("led_hold", {8'h00, LED}, 16'h0055);
      rd("rd_led_hold", 16'h0002, 16'h0055);

`ifndef IO_DEBOUNCE_EN
      // Two-edge synchroniser latency.
      switches = 4'b1010;
      button_1 = 1'b1;
      tick();
      rd("sw_1edge", 16'h0001, 16'h0000);
      rd("btn_1edge", 16'h0000, 16'h0000);
      tick();
      rd("sw_2edge", 16'h0001, 16'h000A);
      rd("btn_2edge", 16'h0000, 16'h0001);

      button_1 = 1'b0;
      repeat (4) tick();
      do_write(16'h0003, 16'h0001);
      rd("evt_clr0", 16'h0003, 16'h0000);

      // Pulse for 5 cycles: flag sets and stays after release.
      button_1 = 1'b1;
      repeat (5) tick();
      button_1 = 1'b0;
      repeat (4) tick();
      rd("evt_sticky", 16'h0003, 16'h0001);
      rd("btn_released", 16'h0000, 16'h0000);
      do_write(16'h0003, 16'hFFFE);
      rd("evt_no_clr_bit0", 16'h0003, 16'h0001);
      do_write(16'h0003, 16'h0001);
      rd("evt_clr", 16'h0003, 16'h0000);

      // Rising edge lands on the same edge as the clear: set wins.
      button_1 = 1'b1;
      tick();
      tick();
      do_write(16'h0003, 16'h0001);
      rd("evt_set_wins", 16'h0003, 16'h0001);
      do_write(16'h0003, 16'h0001);
      rd("evt_clr_held", 16'h0003, 16'h0000);
      rd("btn_held", 16'h0000, 16'h0001);
      button_1 = 1'b0;
      repeat (3) tick();
`else
      switches = 4'b1010;
      repeat (2) tick();
      rd("sw_2edge", 16'h0001, 16'h000A);

      // Short press is filtered out.
      button_1 = 1'b1;
      repeat (10) tick();
      button_1 = 1'b0;
      repeat (4) tick();
      rd("deb_short_btn", 16'h0000, 16'h0000);
      rd("deb_short_evt", 16'h0003, 16'h0000);

      // Long press gets through.
      button_1 = 1'b1;
      repeat (30) tick();
      rd("deb_long_btn", 16'h0000, 16'h0001);
      rd("deb_long_evt", 16'h0003, 16'h0001);
      button_1 = 1'b0;
`endif

      // Scratch, ID, unmapped.
      do_write(16'h0004, 16'hBEEF);
      rd("scratch_beef", 16'h0004, 16'hBEEF);
      rd("id", 16'h0005, 16'h10A5);
      do_write(16'h00FF, 16'h1234);
      rd("unmapped", 16'h00FF, 16'h0000);
      rd("scratch_kept", 16'h0004, 16'hBEEF);
      check("led_kept", {8'h00, LED}, 16'h0055);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
